parity_checker_rx: RTL and testbench

Bit-serial receiver and checker for the even-parity words produced by the team's parity generator. Frames are n data bits followed by one parity bit. The block shifts them in MSB first, re-assembles the data word and checks that the XOR of all n+1 bits is 0. Each checked word is presented on a valid/ready output with an error flag. It sits at the receive end of the serial link, ahead of any consumer of `data_out`.

---
 rtl/parity_checker_rx.sv | 146 ++++++++++++++
 tb/tb_parity_checker_rx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/parity_checker_rx.sv
// Bit-serial even-parity frame receiver: n data bits (MSB first) + parity bit, checked word on valid/ready.
// Optional parity-error counter is built when PARITY_CHECKER_RX_ERR_COUNT_EN is defined.
module parity_checker_rx #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         bit_in,
  input  logic         bit_valid,
  input  logic         sof,
  output logic [n-1:0] data_out,
  output logic         parity_err,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         overrun,
  output logic         frame_abort,
  output logic [15:0]  err_count
);

  // state | meaning
  // IDLE  | no frame in progress
  // SHIFT | frame in progress, cnt_q counts bits received (1..n)
  typedef enum logic {IDLE, SHIFT} state_t;

  localparam int CW = $clog2(n + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(n);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [n-1:0]    shift_q, shift_d;
  logic            par_q, par_d;
  logic [n-1:0]    data_q, data_d;
  logic            perr_q, perr_d;
  logic            valid_q, valid_d;
  logic            ovr_q, ovr_d;
  logic            abort_q, abort_d;
  logic            complete;
  logic            err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    data_d   = data_q;
    perr_d   = perr_q;
    valid_d  = valid_q;
    ovr_d    = 1'b0;
    abort_d  = 1'b0;
    complete = 1'b0;
    err      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bit_valid && sof) begin
          shift_d = {{(n-1){1'b0}}, bit_in};
          par_d   = bit_in;
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          if (sof) begin
            // a new start always wins, even over the expected parity bit
            abort_d = 1'b1;
            shift_d = {{(n-1){1'b0}}, bit_in};
            par_d   = bit_in;
            cnt_d   = CW'(1);
          end else if (cnt_q == CNT_LAST) begin
            complete = 1'b1;
            err      = par_q ^ bit_in;
            cnt_d    = '0;
            state_d  = IDLE;
          end else begin
            shift_d = {shift_q[n-2:0], bit_in};
            par_d   = par_q ^ bit_in;
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // a word being drained this cycle frees the slot for a completing frame
    if (complete) begin
      if (!valid_q || out_ready) begin
        data_d  = shift_q;
        perr_d  = err;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  assign data_out    = data_q;
  assign parity_err  = perr_q;
  assign out_valid   = valid_q;
  assign overrun     = ovr_q;
  assign frame_abort = abort_q;

`ifdef PARITY_CHECKER_RX_ERR_COUNT_EN
  logic [15:0] ecnt_q;

  // dropped frames still count; saturates rather than wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      ecnt_q <= '0;
    end else if (complete && err && (ecnt_q != 16'hFFFF)) begin
      ecnt_q <= ecnt_q + 16'd1;
    end
  end

  assign err_count = ecnt_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_parity_checker_rx.sv
// Directed self-checking bench for parity_checker_rx (n=8); honours PARITY_CHECKER_RX_ERR_COUNT_EN.
module tb_parity_checker_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        sof = 1'b0;
  logic [7:0]  data_out;
  logic        parity_err;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        overrun;
  logic        frame_abort;
  logic [15:0] err_count;

  int pass_cnt = 0;
  int total_cnt = 0;
  int abort_cnt = 0;
  int ovr_cnt = 0;
  int valid_cnt = 0;

`ifdef PARITY_CHECKER_RX_ERR_COUNT_EN
  localparam int EC_EN = 1;
`else
  localparam int EC_EN = 0;
`endif

  parity_checker_rx #(.n(8)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
    .data_out(data_out), .parity_err(parity_err), .out_valid(out_valid),
    .out_ready(out_ready), .overrun(overrun), .frame_abort(frame_abort),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  // one clock edge; outputs are observed 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
    abort_cnt += int'(frame_abort);
    ovr_cnt   += int'(overrun);
    valid_cnt += int'(out_valid);
  endtask

  task automatic send_bit(input logic b, input logic s);
    bit_valid = 1'b1;
    bit_in    = b;
    sof       = s;
    tick();
    bit_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p);
    for (int i = 7; i >= 0; i--) send_bit(d[i], i == 7);
    send_bit(p, 1'b0);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total_cnt++; if (data_out !== 8'h00) $display("FAIL reset_data got=%h exp=00", data_out); else pass_cnt++;
    total_cnt++; if (parity_err !== 1'b0) $display("FAIL reset_perr got=%b exp=0", parity_err); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid); else pass_cnt++;
    total_cnt++; if (overrun !== 1'b0) $display("FAIL reset_ovr got=%b exp=0", overrun); else pass_cnt++;
    total_cnt++; if (frame_abort !== 1'b0) $display("FAIL reset_abort got=%b exp=0", frame_abort); else pass_cnt++;
    total_cnt++; if (err_count !== 16'd0) $display("FAIL reset_errcnt got=%0d exp=0", err_count); else pass_cnt++;
  endtask

  task automatic test_good_frame();
    send_frame(8'hA5, 1'b0);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL good_valid got=%b exp=1", out_valid); else pass_cnt++;
    total_cnt++; if (data_out !== 8'hA5) $display("FAIL good_data got=%h exp=a5", data_out); else pass_cnt++;
    total_cnt++; if (parity_err !== 1'b0) $display("FAIL good_perr got=%b exp=0", parity_err); else pass_cnt++;
    total_cnt++; if (err_count !== 16'd0) $display("FAIL good_errcnt got=%0d exp=0", err_count); else pass_cnt++;
    tick();
    total_cnt++; if (out_valid !== 1'b1 || data_out !== 8'hA5) $display("FAIL good_hold valid=%b data=%h exp 1/a5", out_valid, data_out); else pass_cnt++;
    drain();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL good_drain got=%b exp=0", out_valid); else pass_cnt++;
    total_cnt++; if (data_out !== 8'hA5) $display("FAIL good_keep got=%h exp=a5", data_out); else pass_cnt++;
  endtask

  task automatic test_bad_parity();
    out_ready = 1'b1;
    send_frame(8'hA5, 1'b1);
    out_ready = 1'b0;
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL bad_valid got=%b exp=1", out_valid); else pass_cnt++;
    total_cnt++; if (data_out !== 8'hA5) $display("FAIL bad_data got=%h exp=a5", data_out); else pass_cnt++;
    total_cnt++; if (parity_err !== 1'b1) $display("FAIL bad_perr got=%b exp=1", parity_err); else pass_cnt++;
    total_cnt++; if (err_count !== 16'(EC_EN)) $display("FAIL bad_errcnt got=%0d exp=%0d", err_count, EC_EN); else pass_cnt++;
    drain();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL bad_drain got=%b exp=0", out_valid); else pass_cnt++;
  endtask

  task automatic test_gaps();
    logic [7:0] d;
    d = 8'h07;
    valid_cnt = 0;
    for (int i = 7; i >= 0; i--) begin
      send_bit(d[i], i == 7);
      for (int g = 0; g < (i % 3) + 1; g++) tick();
    end
    total_cnt++; if (valid_cnt !== 0) $display("FAIL gaps_early got=%0d exp=0", valid_cnt); else pass_cnt++;
    send_bit(1'b1, 1'b0);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL gaps_valid got=%b exp=1", out_valid); else pass_cnt++;
    total_cnt++; if (data_out !== 8'h07) $display("FAIL gaps_data got=%h exp=07", data_out); else pass_cnt++;
    total_cnt++; if (parity_err !== 1'b0) $display("FAIL gaps_perr got=%b exp=0", parity_err); else pass_cnt++;
    drain();
  endtask

  task automatic test_abort();
    abort_cnt = 0;
    valid_cnt = 0;
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    total_cnt++; if (frame_abort !== 1'b1) $display("FAIL abort_pulse got=%b exp=1", frame_abort); else pass_cnt++;
    for (int i = 6; i >= 0; i--) send_bit(i[2:0] inside {3'd5, 3'd4, 3'd3, 3'd2}, 1'b0);
    total_cnt++; if (valid_cnt !== 0) $display("FAIL abort_early got=%0d exp=0", valid_cnt); else pass_cnt++;
    send_bit(1'b0, 1'b0);
    total_cnt++; if (abort_cnt !== 1) $display("FAIL abort_count got=%0d exp=1", abort_cnt); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b1 || data_out !== 8'h3C) $display("FAIL abort_data valid=%b data=%h exp 1/3c", out_valid, data_out); else pass_cnt++;
    total_cnt++; if (parity_err !== 1'b0) $display("FAIL abort_perr got=%b exp=0", parity_err); else pass_cnt++;
    drain();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL abort_single got=%b exp=0", out_valid); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    ovr_cnt = 0;
    send_frame(8'h11, 1'b0);
    send_frame(8'h22, 1'b1);
    total_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_pulse got=%b exp=1", overrun); else pass_cnt++;
    total_cnt++; if (data_out !== 8'h11 || parity_err !== 1'b0) $display("FAIL ovr_keep data=%h perr=%b exp 11/0", data_out, parity_err); else pass_cnt++;
    total_cnt++; if (err_count !== 16'(2 * EC_EN)) $display("FAIL ovr_errcnt got=%0d exp=%0d", err_count, 2 * EC_EN); else pass_cnt++;
    tick();
    total_cnt++; if (ovr_cnt !== 1) $display("FAIL ovr_count got=%0d exp=1", ovr_cnt); else pass_cnt++;
    drain();
    ovr_cnt = 0;
    send_frame(8'h11, 1'b0);
    for (int i = 7; i >= 0; i--) send_bit(i == 5 || i == 1, i == 7);
    out_ready = 1'b1;
    send_bit(1'b0, 1'b0);
    out_ready = 1'b0;
    total_cnt++; if (ovr_cnt !== 0) $display("FAIL b2b_ovr got=%0d exp=0", ovr_cnt); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b1 || data_out !== 8'h22) $display("FAIL b2b_data valid=%b data=%h exp 1/22", out_valid, data_out); else pass_cnt++;
    drain();
  endtask

  task automatic test_reset_mid();
    send_frame(8'h11, 1'b0);
    send_bit(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++; if (out_valid !== 1'b0 || data_out !== 8'h00 || parity_err !== 1'b0) $display("FAIL rstmid_out valid=%b data=%h perr=%b exp 0/00/0", out_valid, data_out, parity_err); else pass_cnt++;
    total_cnt++; if (overrun !== 1'b0 || frame_abort !== 1'b0 || err_count !== 16'd0) $display("FAIL rstmid_misc ovr=%b abort=%b cnt=%0d exp 0/0/0", overrun, frame_abort, err_count); else pass_cnt++;
    valid_cnt = 0;
    ovr_cnt   = 0;
    abort_cnt = 0;
    for (int i = 0; i < 12; i++) send_bit(1'b1, 1'b0);
    tick();
    total_cnt++; if (valid_cnt !== 0 || ovr_cnt !== 0 || abort_cnt !== 0) $display("FAIL rstmid_idle valid=%0d ovr=%0d abort=%0d exp 0/0/0", valid_cnt, ovr_cnt, abort_cnt); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_parity();
    test_gaps();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
